// File: rtl/scanchain_pkg.sv
// ----------------------------------------------------------------------------
// scanchain_pkg
//   Shared definitions for the scan-chain write path: the arbiter FSM state
//   encoding and the default scan address / payload widths that the arbiter,
//   the scan-chain writer and the command decoder must all agree on.
// ----------------------------------------------------------------------------
package scanchain_pkg;

  // Default scan geometry; the writer is built with the same values.
  localparam int SCAN_ADDR_BITS    = 12;
  localparam int SCAN_PAYLOAD_BITS = 160;

  // Default number of cycles the writer may keep write_ready high after
  // accepting a write before the arbiter gives up on it.
  localparam int SCAN_START_TIMEOUT = 16;

  // Arbiter FSM states.
  //   IDLE       : searching for a requester, req_ready may be granted
  //   ISSUE      : captured write presented to the writer (wr_valid high)
  //   WAIT_START : writer accepted, waiting for it to drop wr_ready
  //   WAIT_DONE  : writer shifting, waiting for wr_ready to return
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/scanchain_arbiter_if.sv
// ----------------------------------------------------------------------------
// scanchain_arbiter_if
//   Bundles the requester side, the writer side and the status outputs of
//   the scan-chain arbiter.
//
//   Requester side (NUM_REQ lanes, packed, lane i at [i*W +: W]):
//     req_valid, req_addr, req_payload, req_reset  -> arbiter
//     req_ready (one-hot grant), req_done (pulse)  <- arbiter
//   Writer side:
//     wr_valid, wr_addr, wr_payload, wr_reset      <- arbiter
//     wr_ready                                     -> arbiter
//   Status:
//     busy, grant_id, err_timeout                  <- arbiter
//
//   Modports:
//     slave  : the arbiter itself
//     master : the environment (requesters + writer + monitor)
// ----------------------------------------------------------------------------
interface scanchain_arbiter_if #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_BITS    = scanchain_pkg::SCAN_ADDR_BITS,
  parameter int PAYLOAD_BITS = scanchain_pkg::SCAN_PAYLOAD_BITS,
  parameter int ID_W         = $clog2(NUM_REQ)
);

  // Requester side
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr;
  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_payload;
  logic [NUM_REQ-1:0]              req_reset;
  logic [NUM_REQ-1:0]              req_done;

  // Writer side
  logic                            wr_valid;
  logic                            wr_ready;
  logic [ADDR_BITS-1:0]            wr_addr;
  logic [PAYLOAD_BITS-1:0]         wr_payload;
  logic                            wr_reset;

  // Status
  logic                            busy;
  logic [ID_W-1:0]                 grant_id;
  logic                            err_timeout;

  modport slave (
    input  req_valid, req_addr, req_payload, req_reset, wr_ready,
    output req_ready, req_done, wr_valid, wr_addr, wr_payload, wr_reset,
           busy, grant_id, err_timeout
  );

  modport master (
    output req_valid, req_addr, req_payload, req_reset, wr_ready,
    input  req_ready, req_done, wr_valid, wr_addr, wr_payload, wr_reset,
           busy, grant_id, err_timeout
  );

endinterface

// File: rtl/scanchain_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker.
//
//   Ports:
//     req_i  [NUM_REQ] : request vector
//     last_i [IDX_W]   : index of the most recent winner (lowest priority)
//     en_i             : when low no grant is produced
//     gnt_o  [NUM_REQ] : one-hot grant, all zero if en_i low or no request
//     idx_o  [IDX_W]   : encoded index of the grant (0 when no grant)
//
//   Search starts at (last_i + 1) mod NUM_REQ and wraps, so the requester
//   served last is considered last.
// ----------------------------------------------------------------------------
module rr_arbiter import scanchain_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    int  cand;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_i) + off) % NUM_REQ;
      if (en_i && !found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scanchain_arbiter.sv
// ----------------------------------------------------------------------------
// scanchain_arbiter
//   Shares one scan-chain writer between NUM_REQ requesters. A round-robin
//   winner's address / payload / reset flag are captured, presented to the
//   writer over wr_valid/wr_ready, and the write is tracked until the writer
//   signals completion by raising wr_ready again. The owner then receives a
//   one-cycle req_done pulse. Only one write is ever outstanding.
//
//   Ports:
//     clk    : system clock
//     reset  : asynchronous, active-high reset
//     bus    : scanchain_arbiter_if.slave
//              requester lanes (req_valid/ready/addr/payload/reset/done),
//              writer handshake (wr_valid/ready/addr/payload/reset),
//              status (busy, grant_id, err_timeout sticky)
//
//   Writer protocol as seen here: the writer holds wr_ready high while idle,
//   accepts on wr_valid&&wr_ready, drops wr_ready once it starts shifting
//   and raises it again when the shift has finished.
// ----------------------------------------------------------------------------
module scanchain_arbiter import scanchain_pkg::*; #(
  parameter int NUM_REQ       = 2,
  parameter int ADDR_BITS     = SCAN_ADDR_BITS,
  parameter int PAYLOAD_BITS  = SCAN_PAYLOAD_BITS,
  parameter int START_TIMEOUT = SCAN_START_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  scanchain_arbiter_if.slave   bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  state_e                    state_q;
  logic [ID_W-1:0]           rr_ptr_q;
  logic [ID_W-1:0]           grant_id_q;
  logic [ADDR_BITS-1:0]      addr_q;
  logic [PAYLOAD_BITS-1:0]   payload_q;
  logic                      scan_rst_q;
  logic                      wr_valid_q;
  logic [NUM_REQ-1:0]        done_q;
  logic                      err_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          cnt_d;

  logic [NUM_REQ-1:0]        gnt;
  logic [ID_W-1:0]           win_idx;
  logic                      arb_en;
  logic                      take;
  logic [ADDR_BITS-1:0]      win_addr;
  logic [PAYLOAD_BITS-1:0]   win_payload;
  logic                      win_rst;
  logic [NUM_REQ-1:0]        owner_onehot;

  // Grants are only offered in IDLE, and not in the IDLE cycle that carries
  // the previous write's done pulse, so a done and the next grant never
  // share a cycle. Gating with reset keeps req_ready low while reset is held
  // even though the state has already fallen back to IDLE.
  assign arb_en = (state_q == IDLE) && (done_q == '0) && !reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr (
    .req_i  (bus.req_valid),
    .last_i (rr_ptr_q),
    .en_i   (arb_en),
    .gnt_o  (gnt),
    .idx_o  (win_idx)
  );

  // The arbiter only grants a requester whose valid is high, so any grant
  // bit is a handshake.
  assign take = |gnt;

  assign win_addr     = bus.req_addr[int'(win_idx)*ADDR_BITS +: ADDR_BITS];
  assign win_payload  = bus.req_payload[int'(win_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
  assign win_rst      = bus.req_reset[win_idx];
  assign owner_onehot = NUM_REQ'(1) << grant_id_q;
  assign cnt_d        = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      addr_q     <= '0;
      payload_q  <= '0;
      scan_rst_q <= 1'b0;
      wr_valid_q <= 1'b0;
      done_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (take) begin
            addr_q     <= win_addr;
            payload_q  <= win_payload;
            scan_rst_q <= win_rst;
            rr_ptr_q   <= win_idx;
            grant_id_q <= win_idx;
            wr_valid_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.wr_ready) begin
            wr_valid_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (!bus.wr_ready) begin
            state_q <= WAIT_DONE;
          end else begin
            cnt_q <= cnt_d;
            // Writer never started shifting: release the requester anyway
            // so the chain is not locked up, and leave a sticky flag.
            if (cnt_d == CNT_W'(START_TIMEOUT)) begin
              err_q   <= 1'b1;
              done_q  <= owner_onehot;
              state_q <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (bus.wr_ready) begin
            done_q  <= owner_onehot;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = gnt;
  assign bus.req_done    = done_q;
  assign bus.wr_valid    = wr_valid_q;
  assign bus.wr_addr     = addr_q;
  assign bus.wr_payload  = payload_q;
  assign bus.wr_reset    = scan_rst_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.grant_id    = grant_id_q;
  assign bus.err_timeout = err_q;

endmodule

// File: doc/scanchain_arbiter.md
Name: scanchain_arbiter

Overview:
- Shares the single scan-chain writer between NUM_REQ independent requesters, e.g. the UART command decoder and the boot-time config loader.
- Arbitrates round-robin and captures the winner's address, payload and reset flag.
- Presents the captured write to the writer over its valid/ready handshake, then tracks the write to completion.
- Returns a per-requester done pulse, so a requester knows its write has physically finished shifting.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- ADDR_BITS, 12, scan address width; must match the writer.
- PAYLOAD_BITS, 160, scan payload width; must match the writer.
- START_TIMEOUT, 16, cycles to wait for the writer to drop wr_ready after acceptance before flagging an error.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  one-hot grant; a write is taken on req_valid[i]&&req_ready[i].
- req_addr  in  NUM_REQ*ADDR_BITS  packed addresses; requester i occupies slice [i*ADDR_BITS +: ADDR_BITS].
- req_payload  in  NUM_REQ*PAYLOAD_BITS  packed payloads; same slicing rule.
- req_reset  in  NUM_REQ  per-requester scan_reset flag.
- req_done  out  NUM_REQ  one-cycle pulse to the owning requester when its write completes.
- wr_valid  out  1  to writer write_valid.
- wr_ready  in  1  from writer write_ready.
- wr_addr  out  ADDR_BITS  to writer.
- wr_payload  out  PAYLOAD_BITS  to writer.
- wr_reset  out  1  to writer write_reset.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last owner.
- err_timeout  out  1  sticky; set when the START timeout expires.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=NUM_REQ-1, all outputs 0, captured data 0.
- IDLE:
  - Priority search starts at requester (rr_ptr+1) mod NUM_REQ and wraps.
  - req_ready[winner] is combinational: asserted only in IDLE, only for the first valid requester in search order, and only when at least one req_valid is high.
  - With no valid request, all req_ready are 0.
  - On handshake: capture addr/payload/reset, rr_ptr<=winner, grant_id<=winner, go to ISSUE.
- ISSUE:
  - wr_valid=1; wr_addr, wr_payload, wr_reset driven from the captured registers and stable while waiting.
  - On wr_valid&&wr_ready: wr_valid<=0, clear the timeout counter, go to WAIT_START.
  - Minimum latency from req handshake to writer handshake is 1 cycle.
- WAIT_START:
  - wr_ready==0 -> go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches START_TIMEOUT: set err_timeout, pulse req_done[grant_id], go to IDLE.
- WAIT_DONE:
  - Wait for wr_ready==1. Then pulse req_done[grant_id] for exactly 1 cycle and go to IDLE.
  - No upper bound on this wait; scan length sets the duration.
- Exactly one write is outstanding at any time. New requests are never granted before the prior req_done.
- Requester inputs are sampled only on its handshake cycle; later changes to them are ignored.
- req_valid dropping before grant is legal; that requester is simply skipped.
- Round-robin fairness:
  - The requester just served has lowest priority in the next IDLE.
  - With all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0.
- The req_done pulse and the next grant may not coincide: the grant is given in the IDLE cycle after done.
- err_timeout clears only on reset.
- Reset mid-operation:
  - All state returns to reset values immediately and wr_valid drops asynchronously.
  - No req_done is issued for the aborted write.

Decomposition:
- Package scanchain_pkg holds:
  - the state encoding constants (IDLE, ISSUE, WAIT_START, WAIT_DONE);
  - the default ADDR_BITS and PAYLOAD_BITS, shared with the writer and command decoder.
- One sub-module, rr_arbiter:
  - inputs: NUM_REQ request vector, last-grant pointer, enable;
  - outputs: one-hot grant and encoded index.
  - Purely combinational; reused elsewhere.

Test Plan:
- Bench uses the real writer with CLOCKS_PER_SCAN_CLK=10.
- Single write: req_valid[0], addr=12'h0A5, payload=160'h1, reset=0 -> wr_valid 1 cycle after grant; wr_addr=12'h0A5; req_done[0] exactly one pulse after scan_en falls; busy low afterwards.
- Contention: req 0 and 1 both held valid, 4 writes each -> grant order 0,1,0,1,...; no req_ready before the prior req_done; addresses at writer match each owner's values.
- Reset flag: req_reset[1]=1, payload=160'hDEADBEEF -> wr_reset=1 during ISSUE; writer scan_reset high during the shift; req_done[1] pulses.
- Stalled writer: stub holds wr_ready=1 after acceptance for 16 cycles -> err_timeout=1; req_done[0] pulses; FSM returns to IDLE and grants the next request.
- Async reset: assert reset during WAIT_DONE -> wr_valid, busy, req_ready all 0 without a clock edge; no req_done; a fresh request after release is granted normally.
- Input hold: change req_payload[0] the cycle after the handshake -> wr_payload keeps the captured value through the writer handshake.
